// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared definitions for the FPGA reset sequencer.
//   - seq_state_e : sequencer state encodings (S_RESET .. S_RUN)
//   - CAUSE_*     : codes reported on rst_cause
//   - SYNC_STAGES : depth of every input synchroniser
//   - max2        : helper for sizing counters from parameters
package rst_seq_pkg;

  typedef enum logic [2:0] {
    S_RESET       = 3'd0,
    S_WAIT_LOCK   = 3'd1,
    S_HOLD_PERIPH = 3'd2,
    S_HOLD_CORE   = 3'd3,
    S_RUN         = 3'd4
  } seq_state_e;

  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_FPGA = 2'd1;
  localparam logic [1:0] CAUSE_MCU  = 2'd2;
  localparam logic [1:0] CAUSE_LOCK = 2'd3;

  localparam int unsigned SYNC_STAGES = 2;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_debounce.sv
// rst_seq_debounce: 2-flop synchroniser followed by a debounce filter.
// The debounced output only follows the synchronised input after it has
// differed for DEBOUNCE_CYCLES consecutive edges.
// Ports:
//   i_clk   in  core clock
//   i_rst_n in  asynchronous active-low reset
//   i_raw   in  raw asynchronous input
//   o_db    out debounced value (resets to RST_VAL)
module rst_seq_debounce
  import rst_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16000,
  parameter logic        RST_VAL         = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_db
);

  localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DB_W-1:0]        r_cnt;
  logic                   r_db;
  logic [DB_W-1:0]        w_cnt_d;
  logic                   w_db_d;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_cnt  <= '0;
      r_db   <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_cnt  <= w_cnt_d;
      r_db   <= w_db_d;
    end
  end

  // Counter clears whenever the input agrees with the filtered value, so only
  // an unbroken run of differing samples can flip the output.
  always_comb begin
    w_db_d  = r_db;
    w_cnt_d = '0;
    if (w_sync != r_db) begin
      if (r_cnt == DB_LAST) begin
        w_db_d = w_sync;
      end else begin
        w_cnt_d = r_cnt + 1'b1;
      end
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/fpga_rst_seq.sv
// fpga_rst_seq: reset sequencer between board buttons, MMCM lock and the SoC.
// Waits for a stable lock with both buttons released, then releases the
// peripheral reset and finally the core reset. Aborts on button or lock loss.
// Optional feature macro: RST_SEQ_WAKEUP_EN (debounced wakeup pad on o_wake_n).
// Ports:
//   i_clk          in  core clock
//   i_rst_n        in  asynchronous active-low reset
//   i_fpga_btn_n   in  raw FPGA reset button, active-low
//   i_mcu_btn_n    in  raw MCU reset button, active-low
//   i_mmcm_locked  in  raw MMCM lock flag
//   i_wake_btn_n   in  raw wakeup pad, active-low (macro builds only)
//   o_periph_rst   out active-high peripheral reset
//   o_core_rst_n   out active-low SoC reset
//   o_ready        out high only in RUN
//   o_seq_state    out current state encoding
//   o_rst_cause    out cause of last abort (0 POR, 1 FPGA, 2 MCU, 3 lock)
//   o_wake_n       out debounced wakeup, active-low (1 without the macro)
module fpga_rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16000,
  parameter int unsigned LOCK_STABLE     = 256,
  parameter int unsigned PERIPH_HOLD     = 16,
  parameter int unsigned CORE_HOLD       = 64
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_fpga_btn_n,
  input  logic       i_mcu_btn_n,
  input  logic       i_mmcm_locked,
  input  logic       i_wake_btn_n,
  output logic       o_periph_rst,
  output logic       o_core_rst_n,
  output logic       o_ready,
  output logic [2:0] o_seq_state,
  output logic [1:0] o_rst_cause,
  output logic       o_wake_n
);

  localparam int unsigned CNT_MAX = max2(max2(LOCK_STABLE, PERIPH_HOLD),
                                         max2(CORE_HOLD, DEBOUNCE_CYCLES));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_HOLD - 1);
  localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(CORE_HOLD - 1);

  seq_state_e             r_state;
  seq_state_e             w_state_d;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_d;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic [1:0]             r_cause;
  logic [1:0]             w_cause_d;
  logic                   r_periph_rst;
  logic                   r_core_rst_n;
  logic                   r_ready;
  logic                   w_periph_rst_d;
  logic                   w_core_rst_n_d;
  logic                   w_ready_d;
  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic                   w_lock_sync;
  logic                   w_fpga_db;
  logic                   w_mcu_db;
  logic                   w_ok;

  // Lock flag is only synchronised; its own stability is judged by WAIT_LOCK.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lock_sync <= '0;
    end else begin
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], i_mmcm_locked};
    end
  end

  assign w_lock_sync = r_lock_sync[SYNC_STAGES-1];

  rst_seq_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RST_VAL        (1'b1)
  ) u_db_fpga (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_raw  (i_fpga_btn_n),
    .o_db   (w_fpga_db)
  );

  rst_seq_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RST_VAL        (1'b1)
  ) u_db_mcu (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_raw  (i_mcu_btn_n),
    .o_db   (w_mcu_db)
  );

`ifdef RST_SEQ_WAKEUP_EN
  rst_seq_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RST_VAL        (1'b1)
  ) u_db_wake (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_raw  (i_wake_btn_n),
    .o_db   (o_wake_n)
  );
`else
  logic w_unused_wake;
  assign w_unused_wake = i_wake_btn_n;
  assign o_wake_n      = 1'b1;
`endif

  assign w_ok      = w_lock_sync & w_fpga_db & w_mcu_db;
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  // State register (outputs registered alongside so they move with seq_state).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_RESET;
      r_cnt        <= '0;
      r_cause      <= CAUSE_POR;
      r_periph_rst <= 1'b1;
      r_core_rst_n <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_cause      <= w_cause_d;
      r_periph_rst <= w_periph_rst_d;
      r_core_rst_n <= w_core_rst_n_d;
      r_ready      <= w_ready_d;
    end
  end

  // Next-state logic. The counter is shared: it measures lock stability in
  // WAIT_LOCK and the hold time in the two HOLD states.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_cause_d = r_cause;
    case (r_state)
      S_RESET: begin
        w_state_d = S_WAIT_LOCK;
        w_cnt_d   = '0;
      end
      S_WAIT_LOCK: begin
        if (!w_ok) begin
          w_cnt_d = '0;
        end else if (r_cnt == LOCK_LAST) begin
          w_state_d = S_HOLD_PERIPH;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = w_cnt_inc;
        end
      end
      S_HOLD_PERIPH, S_HOLD_CORE, S_RUN: begin
        if (!w_fpga_db) begin
          w_state_d = S_WAIT_LOCK;
          w_cnt_d   = '0;
          w_cause_d = CAUSE_FPGA;
        end else if (!w_lock_sync) begin
          w_state_d = S_WAIT_LOCK;
          w_cnt_d   = '0;
          w_cause_d = CAUSE_LOCK;
        end else if (!w_mcu_db && (r_state != S_HOLD_PERIPH)) begin
          // Core-only reset: peripherals keep running, core held until release.
          w_state_d = S_HOLD_CORE;
          w_cnt_d   = '0;
          w_cause_d = CAUSE_MCU;
        end else if (r_state == S_HOLD_PERIPH) begin
          if (r_cnt == PERIPH_LAST) begin
            w_state_d = S_HOLD_CORE;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = w_cnt_inc;
          end
        end else if (r_state == S_HOLD_CORE) begin
          if (r_cnt == CORE_LAST) begin
            w_state_d = S_RUN;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = w_cnt_inc;
          end
        end
      end
      default: begin
        w_state_d = S_RESET;
        w_cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state, registered above.
  always_comb begin
    w_periph_rst_d = 1'b1;
    w_core_rst_n_d = 1'b0;
    w_ready_d      = 1'b0;
    case (w_state_d)
      S_HOLD_CORE: begin
        w_periph_rst_d = 1'b0;
      end
      S_RUN: begin
        w_periph_rst_d = 1'b0;
        w_core_rst_n_d = 1'b1;
        w_ready_d      = 1'b1;
      end
      default: begin
        w_periph_rst_d = 1'b1;
      end
    endcase
  end

  assign o_periph_rst = r_periph_rst;
  assign o_core_rst_n = r_core_rst_n;
  assign o_ready      = r_ready;
  assign o_seq_state  = r_state;
  assign o_rst_cause  = r_cause;

endmodule

// File: doc/fpga_rst_seq.md
# fpga_rst_seq

Reset sequencer for the FPGA system top. It sits between the board reset buttons, the MMCM lock flag and the e203 SoC. It synchronises and debounces the raw buttons, waits for a stable clock lock, then releases peripheral reset and core reset in a fixed order. It reports its state and the cause of the last reset, and can optionally debounce the wakeup pad.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16000: consecutive stable cycles needed before a debounced input changes (1 ms at 16 MHz); ≥1
- LOCK_STABLE, 256: consecutive good cycles in WAIT_LOCK before sequencing starts; ≥1
- PERIPH_HOLD, 16: cycles spent in HOLD_PERIPH; ≥1
- CORE_HOLD, 64: cycles spent in HOLD_CORE; ≥1

Ports:
- clk  in  1  core clock (16 MHz MMCM output); the only clock
- rst_n  in  1  asynchronous, active-low reset
- fpga_btn_n  in  1  raw FPGA reset button, active-low, asynchronous
- mcu_btn_n  in  1  raw MCU reset button, active-low, asynchronous
- mmcm_locked  in  1  MMCM lock flag, asynchronous
- wake_btn_n  in  1  raw wakeup pad, active-low (used only with the macro)
- periph_rst  out  1  active-high peripheral reset
- core_rst_n  out  1  active-low SoC reset, drives aon_erst_n
- ready  out  1  high only in RUN
- seq_state  out  3  current state encoding
- rst_cause  out  2  0 = POR, 1 = FPGA button, 2 = MCU button, 3 = lock loss
- wake_n  out  1  debounced wakeup, active-low (tied 1 without the macro)

## Operation
- Input synchronisers: each raw input passes through a 2-flop synchroniser. The button and wake synchronisers reset to 1; the lock synchroniser resets to 0.
- Debounce:
  - Each debounced value resets to 1 (released).
  - A per-input counter clears whenever the synchronised value equals the debounced value.
  - The debounced value takes the synchronised value at the DEBOUNCE_CYCLES-th consecutive differing edge.
- Define ok = lock_sync AND fpga_db AND mcu_db.
- States (seq_state):
  - RESET = 0: always moves to WAIT_LOCK on the next edge.
  - WAIT_LOCK = 1: the counter increments at each edge where ok holds and clears when ok is false. It moves to HOLD_PERIPH at the LOCK_STABLE-th consecutive ok edge.
  - HOLD_PERIPH = 2: lasts exactly PERIPH_HOLD cycles, then moves to HOLD_CORE.
  - HOLD_CORE = 3: lasts exactly CORE_HOLD cycles, then moves to RUN.
  - RUN = 4: terminal state.
- Aborts, evaluated in HOLD_PERIPH, HOLD_CORE and RUN, highest priority first:
  - fpga_db = 0 → WAIT_LOCK, cause = 1.
  - lock_sync = 0 → WAIT_LOCK, cause = 3.
  - mcu_db = 0, in HOLD_CORE or RUN only → HOLD_CORE with the counter cleared, cause = 2. The state is held with the counter at 0 while mcu_db = 0, and counting resumes on release. Peripherals stay out of reset.
  - mcu_db = 0 in HOLD_PERIPH → no effect, because periph_rst is already asserted.
- Every abort clears the counter.
- rst_cause is written only on an abort and is never cleared except by rst_n.
- Outputs are decoded from the next state and registered:
  - periph_rst = 1 in RESET, WAIT_LOCK and HOLD_PERIPH.
  - core_rst_n = 1 only in RUN.
  - ready = 1 only in RUN.
- Counter width is $clog2 of the maximum of LOCK_STABLE, PERIPH_HOLD, CORE_HOLD and DEBOUNCE_CYCLES, plus 1. The counter saturates and never wraps.

## Timing
- Reset values:
  - periph_rst = 1, core_rst_n = 0, ready = 0
  - seq_state = 0, rst_cause = 0, wake_n = 1
- Outputs change on the same edge as seq_state; they have no combinational path from the inputs.
- Latencies:
  - Raw input → synchronised value: 2 edges.
  - Synchronised value → debounced value: DEBOUNCE_CYCLES edges.
  - Debounced event or lock loss → outputs asserted: 1 edge.
- Asserting rst_n mid-sequence immediately forces all outputs to their reset values and clears rst_cause.
- Simultaneous FPGA button and lock loss: cause = 1.

## Configuration
- Macro RST_SEQ_WAKEUP_EN.
- When defined: wake_btn_n gets its own synchroniser and debounce instance, and the result drives wake_n. It does not affect the state machine.
- When undefined: no wake logic is built, wake_btn_n is ignored, and wake_n is constant 1.

## Structure
- Package rst_seq_pkg holds:
  - the state encodings (S_RESET … S_RUN)
  - the cause codes (CAUSE_POR, CAUSE_FPGA, CAUSE_MCU, CAUSE_LOCK)
  - the synchroniser depth constant (2)
- Sub-module rst_seq_debounce, parameterised by DEBOUNCE_CYCLES and reset value, contains the synchroniser plus debounce counter. It is instantiated two or three times.

## Test plan
Benches run with DEBOUNCE_CYCLES = 4, LOCK_STABLE = 8, PERIPH_HOLD = 4, CORE_HOLD = 6. Edges are counted from rst_n deassertion.
- POR with mmcm_locked = 1 throughout → periph_rst falls after edge 14; core_rst_n and ready rise after edge 20; rst_cause = 0.
- Lock toggles low for 1 cycle during WAIT_LOCK → counter restarts; the periph_rst fall moves later by the number of lost edges.
- In RUN, mmcm_locked low for 3 cycles → periph_rst = 1 and core_rst_n = 0 one edge after lock_sync drops; seq_state = 1; rst_cause = 3.
- In RUN, mcu_btn_n held low for 20 cycles → core_rst_n = 0 after 2 + 4 + 1 edges, periph_rst stays 0, rst_cause = 2; core_rst_n returns high 6 edges after mcu_db rises.
- fpga_btn_n glitch low for 3 cycles → no state change; a 10-cycle press → seq_state = 1 and rst_cause = 1.
- With RST_SEQ_WAKEUP_EN defined, wake_btn_n low for 10 cycles → wake_n falls 6 edges after the input falls. Without the macro, wake_n stays 1.
